// File: rtl/vc_controller.sv
// ============================================================================
// Module   : vc_controller
// Brief    : 8-way victim-cache control FSM with a true-LRU stack and per-way
//            valid/dirty tracking. Define VC_PERF_CNT_EN for hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_controller #(
  parameter int WAY_W = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          l1_req,
  input  logic                          l1_evict_valid,
  input  logic                          l1_evict_dirty,
  output logic                          l1_resp,
  output logic                          l1_fill_from_vc,
  input  logic                          vc_hit,
  input  logic [WAY_W-1:0]              vc_hit_way,
  output logic [WAY_W-1:0]              sel_way,
  output logic                          load_entry,
  output logic [WAY_W*(2**WAY_W)-1:0]   lru_stack,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic                          pmem_addr_sel,
  input  logic                          pmem_resp,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
);

  localparam int c_num_ways = 2**WAY_W;
  localparam int c_lru_w    = WAY_W * c_num_ways;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    SWAP   = 3'd2,
    FETCH  = 3'd3,
    WB     = 3'd4,
    INSERT = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WAY_W-1:0]        r_victim;
  logic                    r_from_vc;
  logic [c_num_ways-1:0]   r_valid;
  logic [c_num_ways-1:0]   r_dirty;
  logic [c_lru_w-1:0]      r_lru;

  // Stack slot p holds way p, so way 0 starts as LRU.
  function automatic logic [c_lru_w-1:0] f_lru_init();
    logic [c_lru_w-1:0] r;
    r = '0;
    for (int p = 0; p < c_num_ways; p++) r[p*WAY_W +: WAY_W] = WAY_W'(p);
    return r;
  endfunction

  function automatic logic [c_lru_w-1:0] f_to_mru(input logic [c_lru_w-1:0] s,
                                                  input logic [WAY_W-1:0]   w);
    logic [c_lru_w-1:0] r;
    logic               found;
    r     = s;
    found = 1'b0;
    for (int p = 0; p < c_num_ways-1; p++) begin
      if (s[p*WAY_W +: WAY_W] == w) found = 1'b1;
      if (found) r[p*WAY_W +: WAY_W] = s[(p+1)*WAY_W +: WAY_W];
    end
    r[c_lru_w-1 -: WAY_W] = w;
    return r;
  endfunction

  function automatic logic [c_lru_w-1:0] f_to_lru(input logic [c_lru_w-1:0] s,
                                                  input logic [WAY_W-1:0]   w);
    logic [c_lru_w-1:0] r;
    logic               found;
    r     = s;
    found = 1'b0;
    for (int p = c_num_ways-1; p > 0; p--) begin
      if (s[p*WAY_W +: WAY_W] == w) found = 1'b1;
      if (found) r[p*WAY_W +: WAY_W] = s[(p-1)*WAY_W +: WAY_W];
    end
    r[WAY_W-1:0] = w;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_victim  <= '0;
      r_from_vc <= 1'b0;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_lru     <= f_lru_init();
    end else begin
      r_state <= w_next_state;
      case (r_state)
        LOOKUP: r_victim <= vc_hit ? vc_hit_way : r_lru[WAY_W-1:0];
        SWAP: begin
          r_from_vc <= 1'b1;
          if (l1_evict_valid) begin
            r_valid[r_victim] <= 1'b1;
            r_dirty[r_victim] <= l1_evict_dirty;
            r_lru             <= f_to_mru(r_lru, r_victim);
          end else begin
            r_valid[r_victim] <= 1'b0;
            r_dirty[r_victim] <= 1'b0;
            r_lru             <= f_to_lru(r_lru, r_victim);
          end
        end
        FETCH: r_from_vc <= 1'b0;
        INSERT: begin
          r_valid[r_victim] <= 1'b1;
          r_dirty[r_victim] <= l1_evict_dirty;
          r_lru             <= f_to_mru(r_lru, r_victim);
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from the state register only, so an async reset drops them at once.
  always_comb begin
    w_next_state    = r_state;
    l1_resp         = 1'b0;
    l1_fill_from_vc = 1'b0;
    load_entry      = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_addr_sel   = 1'b0;
    case (r_state)
      IDLE:   if (l1_req) w_next_state = LOOKUP;
      LOOKUP: w_next_state = vc_hit ? SWAP : FETCH;
      SWAP: begin
        l1_fill_from_vc = 1'b1;
        load_entry      = l1_evict_valid;
        w_next_state    = RESP;
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          if (!l1_evict_valid)                         w_next_state = RESP;
          else if (r_valid[r_victim] && r_dirty[r_victim]) w_next_state = WB;
          else                                         w_next_state = INSERT;
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) w_next_state = INSERT;
      end
      INSERT: begin
        load_entry   = 1'b1;
        w_next_state = RESP;
      end
      RESP: begin
        l1_resp         = 1'b1;
        l1_fill_from_vc = r_from_vc;
        w_next_state    = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign sel_way   = r_victim;
  assign lru_stack = r_lru;

`ifdef VC_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (vc_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_controller.sv
// ============================================================================
// Module   : tb_vc_controller
// Brief    : Scoreboard bench for vc_controller; honours VC_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_controller;

  localparam int c_pmem_dly = 4;

  logic        clk;
  logic        reset_n;
  logic        l1_req;
  logic        l1_evict_valid;
  logic        l1_evict_dirty;
  logic        l1_resp;
  logic        l1_fill_from_vc;
  logic        vc_hit;
  logic [2:0]  vc_hit_way;
  logic [2:0]  sel_way;
  logic        load_entry;
  logic [23:0] lru_stack;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_addr_sel;
  logic        pmem_resp;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  vc_controller #(.WAY_W(3)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .l1_req          (l1_req),
    .l1_evict_valid  (l1_evict_valid),
    .l1_evict_dirty  (l1_evict_dirty),
    .l1_resp         (l1_resp),
    .l1_fill_from_vc (l1_fill_from_vc),
    .vc_hit          (vc_hit),
    .vc_hit_way      (vc_hit_way),
    .sel_way         (sel_way),
    .load_entry      (load_entry),
    .lru_stack       (lru_stack),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_addr_sel   (pmem_addr_sel),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  typedef struct {
    logic        fill;
    logic [23:0] lru;
    int          rd;
    int          wr;
    int          wb_way;
    int          loads;
    int          load_way;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;

  // Reference model: order[0] is MRU, order[$] is LRU.
  logic [2:0] order[$];
  logic [7:0] m_valid;
  logic [7:0] m_dirty;
  int         m_hits;
  int         m_misses;

  // Monitor accumulators for the transaction in flight.
  int         a_rd, a_wr, a_ld, a_ldway;
  bit         a_bad;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack_lru();
    logic [23:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[(7-i)*3 +: 3] = order[i];
    return s;
  endfunction

  function automatic void m_move(input logic [2:0] w, input bit to_mru);
    for (int i = 0; i < order.size(); i++)
      if (order[i] == w) begin
        order.delete(i);
        break;
      end
    if (to_mru) order.push_front(w);
    else        order.push_back(w);
  endfunction

  function automatic void model_reset();
    order.delete();
    for (int i = 7; i >= 0; i--) order.push_back(3'(i));
    m_valid  = '0;
    m_dirty  = '0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic void clear_acc();
    a_rd = 0; a_wr = 0; a_ld = 0; a_ldway = 0; a_bad = 1'b0;
  endfunction

  // pmem answers c_pmem_dly cycles into each read or write burst.
  initial begin
    int pc;
    pc = 0;
    pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (reset_n && (pmem_read || pmem_write)) begin
        pc++;
        if (pc == c_pmem_dly) begin
          pmem_resp = 1'b1;
          pc = 0;
        end
      end else begin
        pc = 0;
      end
    end
  end

  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (pmem_read) begin
        a_rd++;
        if (pmem_addr_sel) a_bad = 1'b1;
      end
      if (pmem_write) begin
        a_wr++;
        if (!pmem_addr_sel) a_bad = 1'b1;
        if (sbq.size() > 0 && 32'(sel_way) != sbq[0].wb_way) a_bad = 1'b1;
      end
      if (pmem_read && pmem_write) a_bad = 1'b1;
      if (load_entry) begin
        a_ld++;
        a_ldway = int'(sel_way);
      end
      if (l1_resp) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("fill_from_vc", 32'(l1_fill_from_vc), 32'(e.fill));
          chk("lru_stack", 32'(lru_stack), 32'(e.lru));
          chk("pmem_read_cycles", a_rd, e.rd);
          chk("pmem_write_cycles", a_wr, e.wr);
          chk("load_entry_count", a_ld, e.loads);
          if (e.loads > 0) chk("load_way", a_ldway, e.load_way);
          chk("latency", cyc - e.issue_cyc, e.lat);
          chk("pmem_protocol", 32'(a_bad), 32'd0);
        end
        clear_acc();
      end
    end
  end

  task automatic issue(input bit hit, input logic [2:0] hw, input bit ev, input bit evd,
                       input bit drop);
    exp_t       e;
    logic [2:0] v;
    @(negedge clk);
    e = '{fill: 1'b0, lru: 24'h0, rd: 0, wr: 0, wb_way: 0, loads: 0, load_way: 0,
          lat: 0, issue_cyc: 0};
    if (hit) begin
      v = hw;
      m_hits++;
      e.fill = 1'b1;
      e.lat  = 3;
      if (ev) begin
        e.loads = 1; e.load_way = int'(v);
        m_valid[v] = 1'b1; m_dirty[v] = evd;
        m_move(v, 1'b1);
      end else begin
        m_valid[v] = 1'b0; m_dirty[v] = 1'b0;
        m_move(v, 1'b0);
      end
    end else begin
      v = order[7];
      m_misses++;
      e.rd = c_pmem_dly;
      if (!ev) begin
        e.lat = 2 + c_pmem_dly;
      end else begin
        if (m_valid[v] && m_dirty[v]) begin
          e.wr = c_pmem_dly; e.wb_way = int'(v);
        end
        e.loads = 1; e.load_way = int'(v);
        m_valid[v] = 1'b1; m_dirty[v] = evd;
        m_move(v, 1'b1);
        e.lat = 3 + e.rd + e.wr;
      end
    end
    e.lru       = pack_lru();
    e.issue_cyc = cyc;
    sbq.push_back(e);
    l1_req = 1'b1; l1_evict_valid = ev; l1_evict_dirty = evd;
    vc_hit = hit;  vc_hit_way = hw;
    if (drop) begin
      @(negedge clk);
      l1_req = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    l1_req = 1'b0; l1_evict_valid = 1'b0; l1_evict_dirty = 1'b0;
    vc_hit = 1'b0; vc_hit_way = 3'd0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!l1_resp && n < 200);
    chk("resp_timeout", 32'(l1_resp), 32'd1);
    if (!l1_resp) sbq.delete();
    idle_inputs();
  endtask

  task automatic txn(input bit hit, input logic [2:0] hw, input bit ev, input bit evd,
                     input bit drop);
    issue(hit, hw, ev, evd, drop);
    wait_resp();
  endtask

  task automatic check_counters(input string tag);
`ifdef VC_PERF_CNT_EN
    chk({tag, "_hit_count"}, hit_count, m_hits);
    chk({tag, "_miss_count"}, miss_count, m_misses);
`else
    chk({tag, "_hit_count"}, hit_count, 32'd0);
    chk({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_l1_resp"}, 32'(l1_resp), 32'd0);
    chk({tag, "_load_entry"}, 32'(load_entry), 32'd0);
    chk({tag, "_pmem_read"}, 32'(pmem_read), 32'd0);
    chk({tag, "_pmem_write"}, 32'(pmem_write), 32'd0);
    chk({tag, "_fill_from_vc"}, 32'(l1_fill_from_vc), 32'd0);
    chk({tag, "_pmem_addr_sel"}, 32'(pmem_addr_sel), 32'd0);
    chk({tag, "_sel_way"}, 32'(sel_way), 32'd0);
    chk({tag, "_lru_stack"}, 32'(lru_stack), 32'hFAC688);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    check_counters("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill all eight ways with dirty victims; the ninth miss must write back way 0.
    for (int i = 0; i < 9; i++) txn(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    txn(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);   // hit into a dirty slot, no writeback
    txn(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);   // invalidating hit demotes way 3
    txn(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);   // miss reuses way 3 without writeback
    txn(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);   // miss with no L1 victim
    txn(1'b1, 3'd4, 1'b1, 1'b1, 1'b1);   // l1_req dropped after acceptance
    check_counters("mid");

    // Reset in the middle of a writeback.
    issue(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!pmem_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wb_reached", 32'(pmem_write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_quiet("async_reset");
    idle_inputs();
    sbq.delete();
    model_reset();
    check_counters("async_reset");
    repeat (2) @(negedge clk);
    clear_acc();
    reset_n = 1'b1;

    txn(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);   // recovery: way 0 filled, no writeback
    check_counters("final");
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
